// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the rv32i pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    localparam logic [1:0] StRun       = 2'd0;
    localparam logic [1:0] StFreeze    = 2'd1;
    localparam logic [1:0] StFlushPend = 2'd2;

    typedef struct packed {
        logic load_pc;
        logic load_ifid;
        logic load_idex;
        logic load_exmem;
        logic load_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic pc_redirect;
    } stage_ctrl_t;

    localparam stage_ctrl_t CtrlIdle   = '0;
    localparam stage_ctrl_t CtrlNormal = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                           1'b0, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CtrlFlush  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                           1'b1, 1'b1, 1'b1, 1'b1};
    // Hold PC and IF/ID, insert a bubble into ID/EX, let the rest drain.
    localparam stage_ctrl_t CtrlBubble = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                           1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: cache freezes, load-use bubbles,
// mispredict flushes, performance counters and a sticky freeze-timeout flag.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             idex_is_load,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             mispredict,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hang_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          hang_q, hang_d;
    logic          freeze, lu_hazard;
    logic          stall_inc, bubble_inc, flush_inc;
    stage_ctrl_t   ctrl;

    assign freeze    = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
    assign lu_hazard = idex_is_load & (idex_rd != 5'd0) &
                       ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    always_comb begin
        ctrl       = CtrlIdle;
        state_d    = state_q;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            stall_inc = (state_q != StRun);
            if (freeze) begin
                // A mispredict seen at any point during a freeze is held until it ends.
                state_d = (mispredict || state_q == StFlushPend) ? StFlushPend : StFreeze;
            end else begin
                state_d = StRun;
                if (mispredict || state_q == StFlushPend) begin
                    ctrl      = CtrlFlush;
                    flush_inc = 1'b1;
                end else if (lu_hazard) begin
                    ctrl       = CtrlBubble;
                    bubble_inc = 1'b1;
                end else begin
                    ctrl = CtrlNormal;
                end
            end
        end
    end

    always_comb begin
        timer_d = '0;
        if (freeze) begin
            timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);
        end
        hang_d = hang_q | (freeze && (timer_q >= TW'(TIMEOUT - 1)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            timer_q <= '0;
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hang_q  <= hang_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign load_pc     = ctrl.load_pc;
    assign load_ifid   = ctrl.load_ifid;
    assign load_idex   = ctrl.load_idex;
    assign load_exmem  = ctrl.load_exmem;
    assign load_memwb  = ctrl.load_memwb;
    assign flush_ifid  = ctrl.flush_ifid;
    assign flush_idex  = ctrl.flush_idex;
    assign flush_exmem = ctrl.flush_exmem;
    assign pc_redirect = ctrl.pc_redirect;
    assign hang_err    = hang_q;

endmodule
